// File: rtl/fp_add_sub_pipe.sv
// Four-stage pipelined IEEE-754 adder/subtractor (unpack, align, add, normalise/round/pack)
// with valid/ready flow control. Define FP_ADD_SUB_SUBNORMAL_EN for gradual underflow; default flushes to zero.
module fp_add_sub_pipe #(
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [EXP_BITS+MANT_BITS:0] a,
  input  logic [EXP_BITS+MANT_BITS:0] b,
  input  logic                        operation_select,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [EXP_BITS+MANT_BITS:0] result,
  output logic [3:0]                  flags
);

  localparam int WIDTH  = 1 + EXP_BITS + MANT_BITS;
  localparam int SW     = MANT_BITS + 1;
  localparam int AW     = MANT_BITS + 4;
  localparam int LW     = $clog2(MANT_BITS + 5);
  localparam int EW     = ((EXP_BITS > LW) ? EXP_BITS : LW) + 2;
  localparam int MAX_SH = MANT_BITS + 3;

  localparam logic [WIDTH-1:0] QNAN =
    {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

  typedef struct packed {
    logic                sign;
    logic [EXP_BITS-1:0] exp;
    logic [SW-1:0]       sig;
    logic                nan;
    logic                snan;
    logic                inf;
  } opnd_t;

  function automatic opnd_t decode_operand(input logic [WIDTH-1:0] v, input logic flip);
    opnd_t                o;
    logic [EXP_BITS-1:0]  e;
    logic [MANT_BITS-1:0] f;
    logic                 ez;
    e      = v[WIDTH-2:MANT_BITS];
    f      = v[MANT_BITS-1:0];
    ez     = (e == '0);
    o.sign = v[WIDTH-1] ^ flip;
    o.nan  = (&e) && (|f);
    o.snan = o.nan && !f[MANT_BITS-1];
    o.inf  = (&e) && !(|f);
`ifdef FP_ADD_SUB_SUBNORMAL_EN
    o.exp  = ez ? EXP_BITS'(1) : e;
    o.sig  = {!ez, f};
`else
    o.exp  = e;
    o.sig  = ez ? '0 : {1'b1, f};
`endif
    return o;
  endfunction

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !rst && !stall;

  // S1: unpack, classify, order by magnitude
  opnd_t               ua, ub;
  logic                swap1, sp1;
  logic [WIDTH-1:0]    sp_res1;
  logic [3:0]          sp_flags1;
  logic [EXP_BITS-1:0] ex1, ey1;

  always_comb begin
    ua        = decode_operand(a, 1'b0);
    ub        = decode_operand(b, operation_select);
    swap1     = {ub.exp, ub.sig} > {ua.exp, ua.sig};
    ex1       = swap1 ? ub.exp : ua.exp;
    ey1       = swap1 ? ua.exp : ub.exp;
    sp1       = 1'b1;
    sp_res1   = QNAN;
    sp_flags1 = '0;
    if (ua.nan || ub.nan)
      sp_flags1 = {ua.snan || ub.snan, 3'b000};
    else if (ua.inf && ub.inf && (ua.sign != ub.sign))
      sp_flags1 = 4'b1000;
    else if (ua.inf)
      sp_res1 = {ua.sign, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
    else if (ub.inf)
      sp_res1 = {ub.sign, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
    else
      sp1 = 1'b0;
  end

  logic                s1_valid, s1_sp, s1_sign, s1_zsign, s1_sub;
  logic [WIDTH-1:0]    s1_sp_res;
  logic [3:0]          s1_sp_flags;
  logic [EXP_BITS-1:0] s1_ex, s1_diff;
  logic [SW-1:0]       s1_mx, s1_my;

  // S2: align the smaller significand, folding shifted-out bits into sticky
  logic [LW-1:0] sh2;
  logic [AW-1:0] yext2, lost2, yal2;

  always_comb begin
    sh2     = (EW'(s1_diff) > EW'(MAX_SH)) ? LW'(MAX_SH) : LW'(s1_diff);
    yext2   = {s1_my, 3'b000};
    lost2   = ~({AW{1'b1}} << sh2);
    yal2    = yext2 >> sh2;
    yal2[0] = yal2[0] | (|(yext2 & lost2));
  end

  logic                s2_valid, s2_sp, s2_sign, s2_zsign, s2_sub;
  logic [WIDTH-1:0]    s2_sp_res;
  logic [3:0]          s2_sp_flags;
  logic [EXP_BITS-1:0] s2_ex;
  logic [AW-1:0]       s2_mx, s2_my;

  // S3: magnitude add/subtract and leading-zero count below the carry bit
  logic [AW:0]   sum3;
  logic [LW-1:0] lzc3;

  always_comb begin
    sum3 = s2_sub ? ({1'b0, s2_mx} - {1'b0, s2_my}) : ({1'b0, s2_mx} + {1'b0, s2_my});
    lzc3 = LW'(AW);
    for (int unsigned i = 0; i < AW; i++)
      if (sum3[i]) lzc3 = LW'(AW - 1 - i);
  end

  logic                s3_valid, s3_sp, s3_sign, s3_zsign;
  logic [WIDTH-1:0]    s3_sp_res;
  logic [3:0]          s3_sp_flags;
  logic [EXP_BITS-1:0] s3_ex;
  logic [AW:0]         s3_sum;
  logic [LW-1:0]       s3_lzc;

  // S4: normalise, round to nearest even, pack, apply special cases
  logic [EW-1:0]                ex4, lz4, sh4;
  logic [EXP_BITS:0]            en4, ef4;
  logic [AW-1:0]                norm4;
  logic                         tiny4, inex4, rnd_up4, ovf4;
  logic [EXP_BITS+MANT_BITS:0]  packed4, rounded4;
  logic [WIDTH-1:0]             res4;
  logic [3:0]                   flg4;

  always_comb begin
    ex4 = EW'(s3_ex);
    lz4 = EW'(s3_lzc);
    sh4 = '0;
    if (s3_sum[AW]) begin
      norm4    = s3_sum[AW:1];
      norm4[0] = s3_sum[1] | s3_sum[0];
      en4      = (EXP_BITS+1)'(ex4 + EW'(1));
    end else begin
`ifdef FP_ADD_SUB_SUBNORMAL_EN
      // Capping the left shift at exponent 1 leaves tiny results already denormalised.
      sh4 = (lz4 < ex4) ? lz4 : ex4 - EW'(1);
`else
      sh4 = lz4;
`endif
      norm4 = s3_sum[AW-1:0] << sh4;
      en4   = (EXP_BITS+1)'(ex4 - sh4);
    end
`ifdef FP_ADD_SUB_SUBNORMAL_EN
    tiny4 = !norm4[AW-1];
`else
    tiny4 = !s3_sum[AW] && (lz4 >= ex4);
`endif
    inex4    = |norm4[2:0];
    rnd_up4  = norm4[2] && (norm4[1] || norm4[0] || norm4[3]);
    ef4      = norm4[AW-1] ? en4 : '0;
    packed4  = {ef4, norm4[AW-2:3]};
    // The increment carries through the fraction into the exponent field.
    rounded4 = packed4 + {{(EXP_BITS+MANT_BITS){1'b0}}, rnd_up4};
    ovf4     = rounded4[EXP_BITS+MANT_BITS:MANT_BITS] >= {1'b0, {EXP_BITS{1'b1}}};
    res4     = {s3_sign, rounded4[EXP_BITS+MANT_BITS-1:0]};
    flg4     = {2'b00, tiny4 && inex4, inex4};
    if (s3_sp) begin
      res4 = s3_sp_res;
      flg4 = s3_sp_flags;
    end else if (s3_sum == '0) begin
      res4 = {s3_zsign, {(WIDTH-1){1'b0}}};
      flg4 = '0;
`ifndef FP_ADD_SUB_SUBNORMAL_EN
    end else if (tiny4) begin
      res4 = {s3_sign, {(WIDTH-1){1'b0}}};
      flg4 = 4'b0011;
`endif
    end else if (ovf4) begin
      res4 = {s3_sign, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
      flg4 = 4'b0101;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
      result    <= res4;
      flags     <= flg4;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_sp       <= sp1;
      s1_sp_res   <= sp_res1;
      s1_sp_flags <= sp_flags1;
      s1_sign     <= swap1 ? ub.sign : ua.sign;
      s1_zsign    <= ua.sign & ub.sign;
      s1_sub      <= ua.sign ^ ub.sign;
      s1_ex       <= ex1;
      s1_diff     <= ex1 - ey1;
      s1_mx       <= swap1 ? ub.sig : ua.sig;
      s1_my       <= swap1 ? ua.sig : ub.sig;

      s2_sp       <= s1_sp;
      s2_sp_res   <= s1_sp_res;
      s2_sp_flags <= s1_sp_flags;
      s2_sign     <= s1_sign;
      s2_zsign    <= s1_zsign;
      s2_sub      <= s1_sub;
      s2_ex       <= s1_ex;
      s2_mx       <= {s1_mx, 3'b000};
      s2_my       <= yal2;

      s3_sp       <= s2_sp;
      s3_sp_res   <= s2_sp_res;
      s3_sp_flags <= s2_sp_flags;
      s3_sign     <= s2_sign;
      s3_zsign    <= s2_zsign;
      s3_ex       <= s2_ex;
      s3_sum      <= sum3;
      s3_lzc      <= lzc3;
    end
  end

endmodule
